// File: rtl/cond_unit_ex.sv
// Execute-stage condition unit: holds the NZCV flag register, evaluates the
// ARM condition field of the instruction in E and gates the decoder's
// write/branch requests into committed controls.
// Optional feature macro: CONDEX_PERF_EN adds a saturating SquashCnt output
// counting condition-failed live instructions.
module cond_unit_ex #(
    parameter logic [3:0] FLAG_RST = 4'b0000,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWE,
    input  logic             PCSE,
    input  logic             BranchE,
    input  logic             RegWE,
    input  logic             MemWE,
    input  logic             NoWriteE,
    input  logic [3:0]       ALUFlags,
    output logic             CondExE,
    output logic             PCSrcE,
    output logic             BranchTakenE,
    output logic             RegWriteE,
    output logic             MemWriteE,
`ifdef CONDEX_PERF_EN
    output logic [CNT_W-1:0] SquashCnt,
`endif
    output logic [3:0]       Flags
);

    logic [3:0] flags_q;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_pass;
    logic       live;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
    assign Flags = flags_q;

    // Evaluate the condition field against the registered flags.
    always_comb begin
        // NOTE: assign a default before the case so every path drives the
        // output; a missing branch would otherwise infer a latch.
        cond_pass = 1'b0;
        case (CondE)
            4'b0000: cond_pass = flag_z;                          // EQ
            4'b0001: cond_pass = ~flag_z;                         // NE
            4'b0010: cond_pass = flag_c;                          // CS
            4'b0011: cond_pass = ~flag_c;                         // CC
            4'b0100: cond_pass = flag_n;                          // MI
            4'b0101: cond_pass = ~flag_n;                         // PL
            4'b0110: cond_pass = flag_v;                          // VS
            4'b0111: cond_pass = ~flag_v;                         // VC
            4'b1000: cond_pass = flag_c & ~flag_z;                // HI
            4'b1001: cond_pass = ~flag_c | flag_z;                // LS
            4'b1010: cond_pass = (flag_n == flag_v);              // GE
            4'b1011: cond_pass = (flag_n != flag_v);              // LT
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);    // GT
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);     // LE
            4'b1110: cond_pass = 1'b1;                            // AL
            default: cond_pass = 1'b0;                            // reserved: never
        endcase
    end

    // A slot commits only when it holds a real, unstalled, unflushed instruction.
    assign live         = ValidE & ~StallE & ~FlushE & ~reset;
    assign CondExE      = live & cond_pass;
    assign PCSrcE       = PCSE & CondExE;
    assign BranchTakenE = BranchE & CondExE;
    assign RegWriteE    = RegWE & ~NoWriteE & CondExE;
    assign MemWriteE    = MemWE & CondExE;

    // Flag register: N,Z and C,V halves update independently; no bypass, so
    // the next instruction sees the new value in its own E cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (reset) begin
            flags_q <= FLAG_RST;
        end else begin
            if (CondExE && FlagWE[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (CondExE && FlagWE[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

`ifdef CONDEX_PERF_EN
    logic [CNT_W-1:0] squash_q;

    // Saturating count of live instructions whose condition failed.
    always_ff @(posedge clk) begin
        if (reset) begin
            squash_q <= '0;
        end else if (live && !cond_pass && (squash_q != {CNT_W{1'b1}})) begin
            squash_q <= squash_q + 1'b1;
        end
    end

    assign SquashCnt = squash_q;
`else
    // Counter width is meaningless without the counter.
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_cond_unit_ex.sv
// Directed self-checking bench for cond_unit_ex. Counter checks run only
// when CONDEX_PERF_EN is defined; the DUT is built with CNT_W=2 so
// saturation is reached quickly.
module tb_cond_unit_ex;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             ValidE, StallE, FlushE;
    logic [3:0]       CondE;
    logic [1:0]       FlagWE;
    logic             PCSE, BranchE, RegWE, MemWE, NoWriteE;
    logic [3:0]       ALUFlags;
    logic             CondExE, PCSrcE, BranchTakenE, RegWriteE, MemWriteE;
    logic [3:0]       Flags;
`ifdef CONDEX_PERF_EN
    logic [CNT_W-1:0] SquashCnt;
    int               exp_sq;
`endif

    int checks   = 0;
    int failures = 0;

    cond_unit_ex #(.FLAG_RST(4'b0000), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ValidE       (ValidE),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .CondE        (CondE),
        .FlagWE       (FlagWE),
        .PCSE         (PCSE),
        .BranchE      (BranchE),
        .RegWE        (RegWE),
        .MemWE        (MemWE),
        .NoWriteE     (NoWriteE),
        .ALUFlags     (ALUFlags),
        .CondExE      (CondExE),
        .PCSrcE       (PCSrcE),
        .BranchTakenE (BranchTakenE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
`ifdef CONDEX_PERF_EN
        .SquashCnt    (SquashCnt),
`endif
        .Flags        (Flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // mid-cycle, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ValidE = 1'b0; StallE = 1'b0; FlushE = 1'b0; CondE = 4'b1110;
        FlagWE = 2'b00; PCSE = 1'b0; BranchE = 1'b0; RegWE = 1'b0;
        MemWE = 1'b0; NoWriteE = 1'b0; ALUFlags = 4'b0000;
    endtask

    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        // 1: reset held two cycles with a live AL instruction presented
        idle();
        reset = 1'b1; ValidE = 1'b1; CondE = 4'b1110; RegWE = 1'b1; MemWE = 1'b1;
        PCSE = 1'b1; BranchE = 1'b1; FlagWE = 2'b11; ALUFlags = 4'b1111;
        tick();
        #3;
        check("rst_condex", {7'b0, CondExE}, 8'h0);
        check("rst_outs", {4'b0, PCSrcE, BranchTakenE, RegWriteE, MemWriteE}, 8'h0);
        tick();
        #3;
        check("rst_flags", {4'b0, Flags}, 8'h0);
`ifdef CONDEX_PERF_EN
        check("rst_squash", {6'b0, SquashCnt}, 8'h0);
        exp_sq = 0;
`endif
        reset = 1'b0;
        idle();

        // 2: CMP sets Z, then BEQ is taken
        ValidE = 1'b1; CondE = 4'b1110; FlagWE = 2'b11; NoWriteE = 1'b1; RegWE = 1'b1;
        ALUFlags = 4'b0100;
        #3;
        check("cmp_condex", {7'b0, CondExE}, 8'h1);
        check("cmp_regwrite", {7'b0, RegWriteE}, 8'h0);
        check("cmp_flags_not_yet", {4'b0, Flags}, 8'h0);
        tick();
        idle();
        ValidE = 1'b1; CondE = 4'b0000; BranchE = 1'b1; PCSE = 1'b1;
        #3;
        check("beq_flags", {4'b0, Flags}, 8'h4);
        check("beq_pcsrc", {7'b0, PCSrcE}, 8'h1);
        check("beq_taken", {7'b0, BranchTakenE}, 8'h1);
        tick();

        // 3: ADDNE with Z set fails: no writes, no flag update
        idle();
        ValidE = 1'b1; CondE = 4'b0001; FlagWE = 2'b11; RegWE = 1'b1; ALUFlags = 4'b1010;
        #3;
        check("addne_condex", {7'b0, CondExE}, 8'h0);
        check("addne_regwrite", {7'b0, RegWriteE}, 8'h0);
        tick();
        idle();
        #3;
        check("addne_flags_hold", {4'b0, Flags}, 8'h4);
`ifdef CONDEX_PERF_EN
        exp_sq = 1;
        check("addne_squash", {6'b0, SquashCnt}, 8'h1);
`endif

        // 4: independent halves. Set 0010, then NZ-only, then CV-only.
        ValidE = 1'b1; CondE = 4'b1110; FlagWE = 2'b11; ALUFlags = 4'b0010;
        tick();
        FlagWE = 2'b10; ALUFlags = 4'b1111;
        #3;
        check("half_setup", {4'b0, Flags}, 8'h2);
        tick();
        FlagWE = 2'b01; ALUFlags = 4'b0001;
        #3;
        check("half_nz", {4'b0, Flags}, 8'hE);
        tick();
        idle();
        #3;
        check("half_cv", {4'b0, Flags}, 8'hD);

        // 5: STR held by stall, released once, then stall+flush drops it
        ValidE = 1'b1; CondE = 4'b1110; MemWE = 1'b1; StallE = 1'b1;
        FlagWE = 2'b11; ALUFlags = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("stall_memwrite", {7'b0, MemWriteE}, 8'h0);
            tick();
        end
        check("stall_flags_hold", {4'b0, Flags}, 8'hD);
        StallE = 1'b0; FlagWE = 2'b00;
        #3;
        check("release_memwrite", {7'b0, MemWriteE}, 8'h1);
        tick();
        StallE = 1'b1; FlushE = 1'b1; FlagWE = 2'b11;
        #3;
        check("flush_stall_memwrite", {7'b0, MemWriteE}, 8'h0);
        check("flush_stall_condex", {7'b0, CondExE}, 8'h0);
        tick();
        StallE = 1'b0;
        #3;
        check("flush_memwrite", {7'b0, MemWriteE}, 8'h0);
        tick();
        idle();
        #3;
        check("flush_flags_hold", {4'b0, Flags}, 8'hD);

        // 6: full condition sweep against the reference table
        for (int f = 0; f < 16; f++) begin
            idle();
            ValidE = 1'b1; CondE = 4'b1110; FlagWE = 2'b11; ALUFlags = f[3:0];
            tick();
            FlagWE = 2'b00;
            #3;
            check("sweep_flags", {4'b0, Flags}, {4'b0, f[3:0]});
            for (int c = 0; c < 16; c++) begin
                CondE = c[3:0];
                #1;
                check($sformatf("sweep_c%0h_f%0h", c, f), {7'b0, CondExE},
                      {7'b0, ref_pass(c[3:0], f[3:0])});
                tick();
`ifdef CONDEX_PERF_EN
                if (!ref_pass(c[3:0], f[3:0]) && exp_sq < 3) exp_sq++;
                #1;
                check("sweep_squash", {6'b0, SquashCnt}, exp_sq[7:0]);
`endif
            end
        end
`ifdef CONDEX_PERF_EN
        check("squash_saturated", {6'b0, SquashCnt}, 8'h3);
`endif

        // Mid-operation reset returns flags to the reset value
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #3;
        check("reset_again_flags", {4'b0, Flags}, 8'h0);
`ifdef CONDEX_PERF_EN
        check("reset_again_squash", {6'b0, SquashCnt}, 8'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
